// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for a five-stage (IF/ID/EX/MEM/WB) core.
// It tracks an outstanding data-bus transaction, sequences multi-cycle
// multiply/divide operations, and detects load-use hazards. From these it
// drives per-segment hold (stall) and bubble (refresh) controls.
//
// Ports
//   clk, resetn                  clock, synchronous active-low reset
//   exc_flush                    exception/eret committed in MEM
//   id_rs/id_rt(+_ren)           ID-stage source registers and read enables
//   ex_load, ex_regwen, ex_wreg  EX-stage load flag, GPR write, destination
//   ex_rs/ex_rt(+_ren)           EX-stage source registers and read enables
//   ex_mult, ex_div              EX-stage multiply / divide
//   mem_data_en                  MEM-stage data-bus access
//   data_addr_ok, data_data_ok   bus address accepted / data returned
//   wb_regwen, wb_wreg           WB-stage GPR write and destination
//   pc_stall                     hold the PC
//   stall[3:0], refresh[3:0]     hold / bubble per segment (bit0 IF/ID .. bit3 MEM/WB)
//   recode[1:0]                  held ID/EX recaptures operand (bit0 rt, bit1 rs)
//   md_busy                      multiply/divide sequencer active
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int DIV_CYCLES  = 32,
   parameter int MULT_CYCLES = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       exc_flush,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_rs_ren,
   input  logic       id_rt_ren,
   input  logic       ex_load,
   input  logic       ex_regwen,
   input  logic [4:0] ex_wreg,
   input  logic [4:0] ex_rs,
   input  logic [4:0] ex_rt,
   input  logic       ex_rs_ren,
   input  logic       ex_rt_ren,
   input  logic       ex_mult,
   input  logic       ex_div,
   input  logic       mem_data_en,
   input  logic       data_addr_ok,
   input  logic       data_data_ok,
   input  logic       wb_regwen,
   input  logic [4:0] wb_wreg,
   output logic       pc_stall,
   output logic [3:0] stall,
   output logic [3:0] refresh,
   output logic [1:0] recode,
   output logic       md_busy
);

   typedef enum logic [1:0] {
      M_IDLE = 2'd0,
      M_ADDR = 2'd1,
      M_DATA = 2'd2
   } mem_state_t;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   // Counter preload is N-1: the launch cycle itself is the first stall cycle.
   localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);
   localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);

   mem_state_t mem_state_r, mem_state_nxt_s;
   md_state_t  md_state_r,  md_state_nxt_s;
   logic [5:0] cnt_r,       cnt_nxt_s;
   logic       flush_pend_r, flush_pend_nxt_s;

   logic mem_idle_s;
   logic mem_stall_s;
   logic flush_now_s;
   logic md_launch_s;
   logic md_stall_s;
   logic lu_s;
   logic wb_fwd_ok_s;

   assign mem_idle_s  = (mem_state_r == M_IDLE);
   assign mem_stall_s = (mem_idle_s & mem_data_en)
                      | (mem_state_r == M_ADDR)
                      | ((mem_state_r == M_DATA) & ~data_data_ok);

   // A flush is only taken once no bus transaction is in flight, so the
   // outstanding response is never orphaned.
   assign flush_now_s = (exc_flush | flush_pend_r) & mem_idle_s;

   assign md_launch_s = (md_state_r == MD_IDLE) & (ex_mult | ex_div)
                      & ~flush_now_s & ~mem_stall_s;
   assign md_stall_s  = md_launch_s | ((md_state_r == MD_BUSY) & (cnt_r != 6'd0));

   assign lu_s = ex_load & ex_regwen & (ex_wreg != 5'd0)
               & ((id_rs_ren & (id_rs == ex_wreg)) | (id_rt_ren & (id_rt == ex_wreg)));

   assign wb_fwd_ok_s = wb_regwen & (wb_wreg != 5'd0);

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_state_r  <= M_IDLE;
         md_state_r   <= MD_IDLE;
         cnt_r        <= 6'd0;
         flush_pend_r <= 1'b0;
      end else begin
         mem_state_r  <= mem_state_nxt_s;
         md_state_r   <= md_state_nxt_s;
         cnt_r        <= cnt_nxt_s;
         flush_pend_r <= flush_pend_nxt_s;
      end
   end

   // Memory-bus FSM next state.
   always_comb begin
      mem_state_nxt_s = mem_state_r;
      case (mem_state_r)
         M_IDLE: begin
            if (mem_data_en) begin
               if (data_addr_ok) begin
                  mem_state_nxt_s = M_DATA;
               end else begin
                  mem_state_nxt_s = M_ADDR;
               end
            end else begin
               mem_state_nxt_s = M_IDLE;
            end
         end
         M_ADDR: begin
            if (data_addr_ok) begin
               mem_state_nxt_s = M_DATA;
            end else begin
               mem_state_nxt_s = M_ADDR;
            end
         end
         M_DATA: begin
            if (data_data_ok) begin
               mem_state_nxt_s = M_IDLE;
            end else begin
               mem_state_nxt_s = M_DATA;
            end
         end
         default: mem_state_nxt_s = M_IDLE;
      endcase
   end

   // Deferred-flush flag: remembers a flush that arrived mid-transaction.
   always_comb begin
      flush_pend_nxt_s = flush_pend_r;
      if (flush_now_s) begin
         flush_pend_nxt_s = 1'b0;
      end else if (exc_flush & ~mem_idle_s) begin
         flush_pend_nxt_s = 1'b1;
      end else begin
         flush_pend_nxt_s = flush_pend_r;
      end
   end

   // Multiply/divide sequencer next state and counter.
   always_comb begin
      md_state_nxt_s = md_state_r;
      cnt_nxt_s      = cnt_r;
      if (flush_now_s) begin
         md_state_nxt_s = MD_IDLE;
         cnt_nxt_s      = 6'd0;
      end else begin
         case (md_state_r)
            MD_IDLE: begin
               if (md_launch_s) begin
                  md_state_nxt_s = MD_BUSY;
                  cnt_nxt_s      = ex_div ? DIV_LOAD : MULT_LOAD;
               end else begin
                  md_state_nxt_s = MD_IDLE;
               end
            end
            MD_BUSY: begin
               if (cnt_r != 6'd0) begin
                  cnt_nxt_s = cnt_r - 6'd1;
               end else if (!mem_stall_s) begin
                  // Result leaves EX this cycle; a memory stall would keep
                  // the instruction in EX, so wait without relaunching.
                  md_state_nxt_s = MD_IDLE;
               end else begin
                  md_state_nxt_s = MD_BUSY;
               end
            end
            default: begin
               md_state_nxt_s = MD_IDLE;
               cnt_nxt_s      = 6'd0;
            end
         endcase
      end
   end

   // Prioritised pipeline controls; reset looks like a full flush.
   always_comb begin
      pc_stall = 1'b0;
      stall    = 4'b0000;
      refresh  = 4'b0000;
      if (!resetn) begin
         refresh = 4'b1111;
      end else if (flush_now_s) begin
         refresh = 4'b1111;
      end else if (mem_stall_s) begin
         pc_stall = 1'b1;
         stall    = 4'b0111;
         refresh  = 4'b1000;
      end else if (md_stall_s) begin
         pc_stall = 1'b1;
         stall    = 4'b0011;
         refresh  = 4'b0100;
      end else if (lu_s) begin
         pc_stall = 1'b1;
         stall    = 4'b0001;
         refresh  = 4'b0010;
      end else begin
         pc_stall = 1'b0;
         stall    = 4'b0000;
         refresh  = 4'b0000;
      end
   end

   // While ID/EX is held, its operands would miss a value retiring from WB,
   // so the held register recaptures it.
   assign recode[0] = stall[1] & ~flush_now_s & wb_fwd_ok_s & ex_rt_ren & (wb_wreg == ex_rt);
   assign recode[1] = stall[1] & ~flush_now_s & wb_fwd_ok_s & ex_rs_ren & (wb_wreg == ex_rs);

   assign md_busy = resetn & (md_state_r == MD_BUSY);

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl: table of single-cycle vectors from the
// idle state, hand-written multi-cycle sequences, then randomized stimulus
// against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int DIVC = 32;
   localparam int MULC = 2;

   logic       clk = 1'b0;
   logic       resetn;
   logic       exc_flush;
   logic [4:0] id_rs, id_rt;
   logic       id_rs_ren, id_rt_ren;
   logic       ex_load, ex_regwen;
   logic [4:0] ex_wreg, ex_rs, ex_rt;
   logic       ex_rs_ren, ex_rt_ren, ex_mult, ex_div;
   logic       mem_data_en, data_addr_ok, data_data_ok;
   logic       wb_regwen;
   logic [4:0] wb_wreg;
   logic       pc_stall;
   logic [3:0] stall, refresh;
   logic [1:0] recode;
   logic       md_busy;

   always #5 clk = ~clk;

   hazard_ctrl #(.DIV_CYCLES(DIVC), .MULT_CYCLES(MULC)) dut (
      .clk(clk), .resetn(resetn), .exc_flush(exc_flush),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren),
      .ex_load(ex_load), .ex_regwen(ex_regwen), .ex_wreg(ex_wreg),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rs_ren(ex_rs_ren), .ex_rt_ren(ex_rt_ren),
      .ex_mult(ex_mult), .ex_div(ex_div), .mem_data_en(mem_data_en),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .wb_regwen(wb_regwen), .wb_wreg(wb_wreg),
      .pc_stall(pc_stall), .stall(stall), .refresh(refresh),
      .recode(recode), .md_busy(md_busy)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Output bundle layout: {pc_stall, stall[3:0], refresh[3:0], recode[1:0], md_busy}
   function automatic logic [11:0] mk(input logic p, input logic [3:0] s, input logic [3:0] r,
                                      input logic [1:0] c, input logic b);
      return {p, s, r, c, b};
   endfunction

   localparam logic [11:0] E_ZERO = {1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0};
   localparam logic [11:0] E_RST  = {1'b0, 4'b0000, 4'b1111, 2'b00, 1'b0};
   localparam logic [11:0] E_FL   = {1'b0, 4'b0000, 4'b1111, 2'b00, 1'b0};
   localparam logic [11:0] E_MEM  = {1'b1, 4'b0111, 4'b1000, 2'b00, 1'b0};
   localparam logic [11:0] E_MD   = {1'b1, 4'b0011, 4'b0100, 2'b00, 1'b0};
   localparam logic [11:0] E_LU   = {1'b1, 4'b0001, 4'b0010, 2'b00, 1'b0};
   localparam logic [11:0] M_ALL  = 12'hFFF;
   localparam logic [11:0] M_NOBZ = 12'hFFE;

   task automatic check(input string name, input logic [11:0] exp, input logic [11:0] mask);
      logic [11:0] got;
      got = {pc_stall, stall, refresh, recode, md_busy};
      n_vec++;
      if ((got & mask) !== (exp & mask)) begin
         n_bad++;
         $display("FAIL %s @%0t: got pc=%b stall=%b refresh=%b recode=%b busy=%b, expected pc=%b stall=%b refresh=%b recode=%b busy=%b (mask %h)",
                  name, $time, got[11], got[10:7], got[6:3], got[2:1], got[0],
                  exp[11], exp[10:7], exp[6:3], exp[2:1], exp[0], mask);
      end
   endtask

   task automatic clear_in();
      exc_flush = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rs_ren = 1'b0; id_rt_ren = 1'b0;
      ex_load = 1'b0; ex_regwen = 1'b0; ex_wreg = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
      ex_rs_ren = 1'b0; ex_rt_ren = 1'b0; ex_mult = 1'b0; ex_div = 1'b0;
      mem_data_en = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
      wb_regwen = 1'b0; wb_wreg = 5'd0;
   endtask

   // ---------------- behavioural reference model ----------------
   // bus: 0 nothing outstanding, 1 waiting for address accept, 2 waiting for data
   int m_bus;
   int m_left;   // stall cycles still owed by the running mul/div after this one
   bit m_on;     // a mul/div has been launched and its instruction is still in EX
   bit m_pend;   // flush seen while the bus was busy
   bit model_on = 1'b0;

   function automatic void model_terms(output bit fn, output bit ms, output bit la);
      fn = (exc_flush || m_pend) && (m_bus == 0);
      ms = (m_bus == 0 && mem_data_en) || (m_bus == 1) || (m_bus == 2 && !data_data_ok);
      la = !m_on && (ex_mult || ex_div) && !fn && !ms;
   endfunction

   function automatic logic [11:0] model_out();
      bit fn, ms, la, mds, lu, hold_idex;
      logic [11:0] r;
      logic [1:0] rc;
      if (!resetn) return E_RST;
      model_terms(fn, ms, la);
      mds = la || (m_on && m_left > 0);
      lu  = ex_load && ex_regwen && ex_wreg != 5'd0 &&
            ((id_rs_ren && id_rs == ex_wreg) || (id_rt_ren && id_rt == ex_wreg));
      if (fn)       r = E_FL;
      else if (ms)  r = E_MEM;
      else if (mds) r = E_MD;
      else if (lu)  r = E_LU;
      else          r = E_ZERO;
      hold_idex = !fn && (ms || mds);
      rc[0] = hold_idex && wb_regwen && wb_wreg != 5'd0 && ex_rt_ren && wb_wreg == ex_rt;
      rc[1] = hold_idex && wb_regwen && wb_wreg != 5'd0 && ex_rs_ren && wb_wreg == ex_rs;
      r[2:1] = rc;
      r[0] = m_on;
      return r;
   endfunction

   task automatic model_update();
      bit fn, ms, la;
      if (!resetn) begin
         m_bus = 0; m_left = 0; m_on = 1'b0; m_pend = 1'b0;
      end else begin
         model_terms(fn, ms, la);
         if (fn) m_pend = 1'b0;
         else if (exc_flush && m_bus != 0) m_pend = 1'b1;
         if (fn) begin
            m_on = 1'b0; m_left = 0;
         end else if (la) begin
            m_on = 1'b1; m_left = (ex_div ? DIVC : MULC) - 1;
         end else if (m_on) begin
            if (m_left > 0) m_left--;
            else if (!ms) m_on = 1'b0;
         end
         case (m_bus)
            0: if (mem_data_en) m_bus = data_addr_ok ? 2 : 1;
            1: if (data_addr_ok) m_bus = 2;
            2: if (data_data_ok) m_bus = 0;
            default: m_bus = 0;
         endcase
      end
   endtask

   task automatic tick();
      if (model_on) model_update();
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic       exc;
      logic [4:0] id_rs, id_rt;
      logic       id_rs_ren, id_rt_ren, ex_load, ex_regwen;
      logic [4:0] ex_wreg, ex_rs, ex_rt;
      logic       ex_rs_ren, ex_rt_ren, ex_mult, ex_div, mem_en, wb_regwen;
      logic [4:0] wb_wreg;
      logic [11:0] exp;
   } vec_t;

   vec_t vq[$];

   task automatic apply_vec(input vec_t v);
      clear_in();
      exc_flush = v.exc; id_rs = v.id_rs; id_rt = v.id_rt;
      id_rs_ren = v.id_rs_ren; id_rt_ren = v.id_rt_ren;
      ex_load = v.ex_load; ex_regwen = v.ex_regwen; ex_wreg = v.ex_wreg;
      ex_rs = v.ex_rs; ex_rt = v.ex_rt; ex_rs_ren = v.ex_rs_ren; ex_rt_ren = v.ex_rt_ren;
      ex_mult = v.ex_mult; ex_div = v.ex_div; mem_data_en = v.mem_en;
      wb_regwen = v.wb_regwen; wb_wreg = v.wb_wreg;
   endtask

   initial begin
      vec_t v, z;
      z = '0;
      // load-use through rs, through rt; non-hazards
      v = z; v.ex_load = 1; v.ex_regwen = 1; v.ex_wreg = 5; v.id_rs = 5; v.id_rs_ren = 1; v.exp = E_LU; vq.push_back(v);
      v = z; v.ex_load = 1; v.ex_regwen = 1; v.ex_wreg = 9; v.id_rt = 9; v.id_rt_ren = 1; v.exp = E_LU; vq.push_back(v);
      v = z; v.ex_load = 1; v.ex_regwen = 1; v.ex_wreg = 0; v.id_rs = 0; v.id_rs_ren = 1; v.exp = E_ZERO; vq.push_back(v);
      v = z; v.ex_load = 1; v.ex_regwen = 1; v.ex_wreg = 5; v.id_rs = 5; v.id_rs_ren = 0; v.exp = E_ZERO; vq.push_back(v);
      v = z; v.ex_load = 1; v.ex_regwen = 0; v.ex_wreg = 5; v.id_rs = 5; v.id_rs_ren = 1; v.exp = E_ZERO; vq.push_back(v);
      v = z; v.ex_load = 0; v.ex_regwen = 1; v.ex_wreg = 5; v.id_rt = 5; v.id_rt_ren = 1; v.exp = E_ZERO; vq.push_back(v);
      // memory stall, and its priority over mul/div
      v = z; v.mem_en = 1; v.exp = E_MEM; vq.push_back(v);
      v = z; v.mem_en = 1; v.ex_mult = 1; v.exp = E_MEM; vq.push_back(v);
      // mul/div launch, and its priority over load-use
      v = z; v.ex_mult = 1; v.exp = E_MD; vq.push_back(v);
      v = z; v.ex_div = 1; v.ex_load = 1; v.ex_regwen = 1; v.ex_wreg = 3; v.id_rs = 3; v.id_rs_ren = 1; v.exp = E_MD; vq.push_back(v);
      // flush beats everything
      v = z; v.exc = 1; v.exp = E_FL; vq.push_back(v);
      v = z; v.exc = 1; v.mem_en = 1; v.ex_div = 1; v.exp = E_FL; vq.push_back(v);
      v = z; v.exc = 1; v.ex_mult = 1; v.wb_regwen = 1; v.wb_wreg = 7; v.ex_rt = 7; v.ex_rt_ren = 1; v.exp = E_FL; vq.push_back(v);
      // recode while ID/EX is held
      v = z; v.ex_mult = 1; v.wb_regwen = 1; v.wb_wreg = 7; v.ex_rt = 7; v.ex_rt_ren = 1; v.exp = mk(1'b1, 4'b0011, 4'b0100, 2'b01, 1'b0); vq.push_back(v);
      v = z; v.ex_mult = 1; v.wb_regwen = 1; v.wb_wreg = 7; v.ex_rs = 7; v.ex_rs_ren = 1; v.exp = mk(1'b1, 4'b0011, 4'b0100, 2'b10, 1'b0); vq.push_back(v);
      v = z; v.ex_mult = 1; v.wb_regwen = 1; v.wb_wreg = 4; v.ex_rs = 4; v.ex_rs_ren = 1; v.ex_rt = 4; v.ex_rt_ren = 1; v.exp = mk(1'b1, 4'b0011, 4'b0100, 2'b11, 1'b0); vq.push_back(v);
      v = z; v.ex_mult = 1; v.wb_regwen = 1; v.wb_wreg = 0; v.ex_rt = 0; v.ex_rt_ren = 1; v.exp = E_MD; vq.push_back(v);
      v = z; v.mem_en = 1; v.wb_regwen = 1; v.wb_wreg = 12; v.ex_rt = 12; v.ex_rt_ren = 1; v.exp = mk(1'b1, 4'b0111, 4'b1000, 2'b01, 1'b0); vq.push_back(v);
      // load-use does not hold ID/EX, so no recode
      v = z; v.ex_load = 1; v.ex_regwen = 1; v.ex_wreg = 5; v.id_rs = 5; v.id_rs_ren = 1; v.wb_regwen = 1; v.wb_wreg = 6; v.ex_rt = 6; v.ex_rt_ren = 1; v.exp = E_LU; vq.push_back(v);

      // ---- reset behaviour ----
      resetn = 1'b0;
      clear_in();
      for (int i = 0; i < 3; i++) begin
         exc_flush = 1'b1; mem_data_en = 1'b1; ex_div = 1'b1;
         ex_load = 1'b1; ex_regwen = 1'b1; ex_wreg = 5'd2; id_rs = 5'd2; id_rs_ren = 1'b1;
         #2;
         check("reset_outputs", E_RST, M_ALL);
         tick();
      end
      resetn = 1'b1;
      clear_in();
      #2;
      check("post_reset_idle", E_ZERO, M_ALL);

      // ---- table vectors, each from a freshly reset state ----
      foreach (vq[i]) begin
         apply_vec(vq[i]);
         #2;
         check($sformatf("vec%0d", i), vq[i].exp, M_ALL);
         resetn = 1'b0;
         clear_in();
         tick();
         resetn = 1'b1;
      end

      // ---- divide: exactly DIVC stall cycles ----
      clear_in();
      ex_div = 1'b1;
      for (int k = 1; k <= DIVC; k++) begin
         #2;
         check($sformatf("div_stall_c%0d", k), mk(1'b1, 4'b0011, 4'b0100, 2'b00, (k > 1)), M_ALL);
         tick();
      end
      #2;
      check("div_release", E_ZERO, M_NOBZ);
      tick();
      ex_div = 1'b0;
      #2;
      check("div_idle", E_ZERO, M_ALL);
      tick();

      // ---- memory wait: addr_ok on 3rd cycle, data_ok 3 cycles later ----
      clear_in();
      mem_data_en = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         data_addr_ok = (k == 3);
         data_data_ok = (k == 6);
         #2;
         check($sformatf("memwait_c%0d", k), (k == 6) ? E_ZERO : E_MEM, M_ALL);
         tick();
      end
      clear_in();
      #2;
      check("memwait_after", E_ZERO, M_ALL);
      tick();

      // ---- deferred flush ----
      clear_in();
      mem_data_en = 1'b1; data_addr_ok = 1'b1;
      #2; check("dflush_req", E_MEM, M_ALL); tick();
      data_addr_ok = 1'b0; exc_flush = 1'b1;
      #2; check("dflush_pulse", E_MEM, M_ALL); tick();
      exc_flush = 1'b0;
      #2; check("dflush_wait", E_MEM, M_ALL); tick();
      data_data_ok = 1'b1;
      #2; check("dflush_dataok", E_ZERO, M_ALL); tick();
      clear_in();
      #2; check("dflush_taken", E_FL, M_ALL); tick();
      #2; check("dflush_done", E_ZERO, M_ALL); tick();

      // ---- recode across a multiply stall ----
      clear_in();
      ex_mult = 1'b1; ex_rt = 5'd7; ex_rt_ren = 1'b1; wb_regwen = 1'b1; wb_wreg = 5'd7;
      #2; check("recode_launch", mk(1'b1, 4'b0011, 4'b0100, 2'b01, 1'b0), M_ALL); tick();
      wb_wreg = 5'd0;
      #2; check("recode_wb0", mk(1'b1, 4'b0011, 4'b0100, 2'b00, 1'b1), M_ALL); tick();
      wb_wreg = 5'd7;
      #2; check("recode_released", E_ZERO, M_NOBZ); tick();
      clear_in();
      #2; check("recode_idle", E_ZERO, M_ALL); tick();

      // ---- reset abandons in-flight work ----
      clear_in();
      ex_div = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      resetn = 1'b0;
      #2; check("midreset_div", E_RST, M_ALL); tick();
      resetn = 1'b1; clear_in();
      #2; check("midreset_div_after", E_ZERO, M_ALL); tick();
      mem_data_en = 1'b1;
      tick(); tick();
      resetn = 1'b0; tick();
      resetn = 1'b1; clear_in();
      #2; check("midreset_bus_after", E_ZERO, M_ALL); tick();

      // ---- randomized run against the reference model ----
      model_on = 1'b1;
      resetn = 1'b0; clear_in(); tick();
      resetn = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         resetn       = ($urandom_range(0, 99) != 0);
         exc_flush    = ($urandom_range(0, 19) == 0);
         id_rs        = 5'($urandom_range(0, 3));
         id_rt        = 5'($urandom_range(0, 3));
         id_rs_ren    = 1'($urandom_range(0, 1));
         id_rt_ren    = 1'($urandom_range(0, 1));
         ex_load      = 1'($urandom_range(0, 1));
         ex_regwen    = 1'($urandom_range(0, 1));
         ex_wreg      = 5'($urandom_range(0, 3));
         ex_rs        = 5'($urandom_range(0, 3));
         ex_rt        = 5'($urandom_range(0, 3));
         ex_rs_ren    = 1'($urandom_range(0, 1));
         ex_rt_ren    = 1'($urandom_range(0, 1));
         ex_mult      = ($urandom_range(0, 7) == 0);
         ex_div       = ($urandom_range(0, 29) == 0);
         mem_data_en  = ($urandom_range(0, 3) == 0);
         data_addr_ok = 1'($urandom_range(0, 1));
         data_data_ok = ($urandom_range(0, 2) == 0);
         wb_regwen    = 1'($urandom_range(0, 1));
         wb_wreg      = 5'($urandom_range(0, 3));
         #2;
         check("random", model_out(), M_ALL);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
